// File: rtl/fpu_dispatch.sv
// Request/response front end for the fixed-point unit: holds one operation on the
// unit until it reports ready (or a timeout expires) and hands the result to writeback.
module fpu_dispatch #(
  parameter int WIDTH    = 32,
  parameter int TAG_W    = 5,
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_rd,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_rd,
  output logic             rsp_error,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_WAIT);
  localparam logic [1:0]       FPU_ADD  = 2'd0;
  localparam logic [1:0]       FPU_SUB  = 2'd1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] rd_q;
  logic             short_op;
  logic             done;

  // fpu_operation holds the latched op throughout EXEC, so it doubles as the op register
  assign short_op  = (fpu_operation == FPU_ADD) || (fpu_operation == FPU_SUB);
  assign done      = fpu_ready && (short_op || (cnt >= CNT_MIN));
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rd_q          <= '0;
      fpu_operation <= FPU_ADD;
      fpu_operand_1 <= '0;
      fpu_operand_2 <= '0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_rd        <= '0;
      rsp_error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state         <= EXEC;
            cnt           <= '0;
            rd_q          <= req_rd;
            fpu_operation <= req_op;
            fpu_operand_1 <= req_a;
            fpu_operand_2 <= req_b;
          end
        end
        EXEC: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
          // Completion takes priority over a timeout landing in the same cycle
          if (done || (cnt == CNT_MAX)) begin
            state         <= RESP;
            rsp_valid     <= 1'b1;
            rsp_result    <= done ? fpu_result : '0;
            rsp_error     <= ~done;
            rsp_rd        <= rd_q;
            fpu_operation <= FPU_ADD;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch: a behavioural fixed-point unit, a directed vector table,
// randomized transactions scored against a spec-level model, and a reset-abort sequence.
module tb_fpu_dispatch;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_rd;
  logic [WIDTH-1:0] fpu_operand_1;
  logic [WIDTH-1:0] fpu_operand_2;
  logic [1:0]       fpu_operation;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [TAG_W-1:0] rsp_rd;
  logic             rsp_error;
  logic             busy;

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [63:0] mask;
    int          hold;
    logic [31:0] exp_result;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  fpu_dispatch #(.WIDTH(WIDTH), .TAG_W(TAG_W), .MIN_WAIT(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
    .fpu_operation(fpu_operation), .fpu_result(fpu_result), .fpu_ready(fpu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_rd(rsp_rd), .rsp_error(rsp_error), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] isqrt(input logic [63:0] x);
    logic [63:0] r;
    r = 0;
    for (int bitpos = 31; bitpos >= 0; bitpos--) begin
      if ((r + (64'd1 << bitpos)) * (r + (64'd1 << bitpos)) <= x) r = r + (64'd1 << bitpos);
    end
    return r[31:0];
  endfunction

  // Q22.10 unit behaviour: add, subtract, multiply and square root
  function automatic logic [31:0] unit_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin
        prod = {32'd0, a} * {32'd0, b};
        return prod[41:10];
      end
      default: return isqrt({22'd0, a, 10'd0});
    endcase
  endfunction

  always_comb fpu_result = unit_calc(fpu_operation, fpu_operand_1, fpu_operand_2);

  // First ready in EXEC cycle k is honoured for ADD/SUB always, for MUL/SQRT only from k=2;
  // with none honoured by cycle 63 the operation times out
  task automatic ref_model(input vec_t v, output logic [31:0] res, output logic err, output int lat);
    res = 32'd0;
    err = 1'b1;
    lat = 64;
    for (int k = 0; k < 64; k++) begin
      if (v.mask[k] && (v.op < 2'd2 || k >= 2)) begin
        res = unit_calc(v.op, v.a, v.b);
        err = 1'b0;
        lat = k + 1;
        return;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Runs one transaction starting at a negedge in IDLE; returns at the negedge of the guard cycle
  task automatic applyStimulus(input vec_t v);
    int   k;
    logic got;
    logic hold_ok;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_rd    = v.rd;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    checkOutput("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    got = 1'b0;
    hold_ok = 1'b1;
    while (k < 200 && !got) begin
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (fpu_operation !== v.op || fpu_operand_1 !== v.a || fpu_operand_2 !== v.b || busy !== 1'b1)
          hold_ok = 1'b0;
        fpu_ready = (k < 64) ? v.mask[k] : 1'b0;
        @(negedge clk);
        k++;
      end
    end
    fpu_ready = 1'b0;
    checkOutput("exec_inputs_held", hold_ok, 1);
    checkOutput("rsp_arrived", got, 1);
    if (!got) return;
    checkOutput("rsp_latency", k, v.exp_lat);
    checkOutput("rsp_result", rsp_result, v.exp_result);
    checkOutput("rsp_rd", rsp_rd, v.rd);
    checkOutput("rsp_error", rsp_error, v.exp_err);
    checkOutput("resp_fpu_op", fpu_operation, 0);
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1;
      @(negedge clk);
      checkOutput("hold_req_ready", req_ready, 0);
      checkOutput("hold_rsp_valid", rsp_valid, 1);
      checkOutput("hold_rsp_result", rsp_result, v.exp_result);
      checkOutput("hold_rsp_rd", rsp_rd, v.rd);
      checkOutput("hold_rsp_error", rsp_error, v.exp_err);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("guard_rsp_valid", rsp_valid, 0);
    checkOutput("guard_req_ready", req_ready, 1);
    checkOutput("guard_fpu_op", fpu_operation, 0);
    checkOutput("guard_operand_1", fpu_operand_1, 0);
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   seen_valid;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_a     = '0;
    req_b     = '0;
    req_rd    = '0;
    fpu_ready = 1'b0;
    rsp_ready = 1'b0;

    tbl[0] = '{2'd0, 32'h0000_0600, 32'h0000_0800, 5'd3,  64'h1,  0, 32'h0000_0E00, 1'b0, 1};
    tbl[1] = '{2'd2, 32'h0000_0600, 32'h0000_0800, 5'd7,  64'h5,  0, 32'h0000_0C00, 1'b0, 3};
    tbl[2] = '{2'd3, 32'h0000_1000, 32'h1234_5678, 5'd9,  64'h10, 0, 32'h0000_0800, 1'b0, 5};
    tbl[3] = '{2'd2, 32'h0000_0600, 32'h0000_0800, 5'd12, 64'h0,  0, 32'h0000_0000, 1'b1, 64};
    tbl[4] = '{2'd1, 32'h0000_1000, 32'h0000_0400, 5'd31, 64'h1, 10, 32'h0000_0C00, 1'b0, 1};
    tbl[5] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd1,  64'h6,  2, 32'h0000_0000, 1'b0, 2};

    #1;
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_result", rsp_result, 0);
    checkOutput("reset_rsp_rd", rsp_rd, 0);
    checkOutput("reset_rsp_error", rsp_error, 0);
    checkOutput("reset_fpu_op", fpu_operation, 0);
    checkOutput("reset_operands", {fpu_operand_1, fpu_operand_2}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(tbl[i]);

    for (int i = 0; i < 25; i++) begin
      int f;
      rv.op   = 2'($urandom_range(0, 3));
      rv.a    = $urandom_range(0, 32'h000F_FFFF);
      rv.b    = $urandom_range(0, 32'h0000_FFFF);
      rv.rd   = 5'($urandom_range(0, 31));
      f       = $urandom_range(0, 70);
      rv.mask = 64'($urandom_range(0, 3));
      if (f < 64) rv.mask[f] = 1'b1;
      rv.hold = $urandom_range(0, 3);
      ref_model(rv, rv.exp_result, rv.exp_err, rv.exp_lat);
      applyStimulus(rv);
    end

    // Reset three cycles into a MUL must abort it without any response
    req_op    = 2'd2;
    req_a     = 32'h0000_0600;
    req_b     = 32'h0000_0800;
    req_rd    = 5'd5;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    fpu_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    fpu_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_rsp_valid", rsp_valid, 0);
    checkOutput("abort_fpu_op", fpu_operation, 0);
    checkOutput("abort_operand_1", fpu_operand_1, 0);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid++;
    end
    fpu_ready = 1'b0;
    rsp_ready = 1'b0;
    checkOutput("abort_no_response", seen_valid, 0);
    applyStimulus(tbl[0]);
    req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
